// File: rtl/buddy_dram_port.sv
// rtl/buddy_dram_port.sv - single-outstanding AXI4 master moving 512-bit buddy metadata lines
// Optional response watchdog enabled by defining BUDDY_DRAM_TIMEOUT_EN.
module buddy_dram_port #(
  parameter int ADDR_WID      = 32,
  parameter int DRAM_DATA_WID = 512,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                       mem_clk,
  input  logic                       mem_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WID-1:0]        cmd_addr,
  input  logic [DRAM_DATA_WID-1:0]   cmd_wdata,
  input  logic [DRAM_DATA_WID/8-1:0] cmd_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DRAM_DATA_WID-1:0]   rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_WID-1:0]        m_axi_araddr,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  input  logic [DRAM_DATA_WID-1:0]   m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [ADDR_WID-1:0]        m_axi_awaddr,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [DRAM_DATA_WID-1:0]   m_axi_wdata,
  output logic [DRAM_DATA_WID/8-1:0] m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  state_t                     state, state_n;
  logic [ADDR_WID-1:0]        addr_q;
  logic [DRAM_DATA_WID-1:0]   wdata_q;
  logic [DRAM_DATA_WID/8-1:0] wstrb_q;
  logic [DRAM_DATA_WID-1:0]   rdata_q;
  logic                       err_q;
  logic                       aw_done, w_done;
  logic                       stale, tmo_hit, tmo_fire;

  // Every command is a single 64-byte INCR beat.
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd6;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd6;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'd0;

  assign m_axi_araddr = addr_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_wlast  = 1'b1;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;

`ifdef BUDDY_DRAM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = ((state == RD_DATA) || (state == WR_RESP)) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      tmo_cnt <= '0;
    end else if (((state == RD_DATA) || (state == WR_RESP)) && (state_n == state)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // A timed-out transaction still owes one response; swallow it before new work.
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      stale <= 1'b0;
    end else if (tmo_fire) begin
      stale <= 1'b1;
    end else if (stale && ((m_axi_rvalid && m_axi_rlast) || m_axi_bvalid)) begin
      stale <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign stale   = 1'b0;
`endif

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    cmd_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = stale;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = stale;
    rsp_valid     = 1'b0;
    tmo_fire      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !stale;
        if (cmd_valid && !stale) state_n = cmd_write ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) begin
          state_n = RSP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_n  = RSP;
        end
      end
      WR_REQ: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_n = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_n = RSP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_n  = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q  <= {cmd_addr[ADDR_WID-1:6], 6'b0};
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        RD_DATA: begin
          // A non-final beat means the slave broke the single-beat contract.
          if (m_axi_rvalid) begin
            err_q <= err_q | (m_axi_rresp != 2'b00) | !m_axi_rlast;
            if (m_axi_rlast) rdata_q <= m_axi_rdata;
          end else if (tmo_fire) begin
            err_q <= 1'b1;
          end
        end
        WR_REQ: begin
          if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
          if (m_axi_wvalid && m_axi_wready) w_done <= 1'b1;
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            err_q <= err_q | (m_axi_bresp != 2'b00);
          end else if (tmo_fire) begin
            err_q <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buddy_dram_port.sv
// tb/tb_buddy_dram_port.sv - scoreboard bench for buddy_dram_port
// Timeout scenario runs only when BUDDY_DRAM_TIMEOUT_EN is defined.
module tb_buddy_dram_port;

  logic         mem_clk = 1'b0;
  logic         mem_rst;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [511:0] cmd_wdata;
  logic [63:0]  cmd_wstrb;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [511:0] rsp_rdata;
  logic [31:0]  m_axi_araddr, m_axi_awaddr;
  logic         m_axi_arvalid, m_axi_arready, m_axi_awvalid, m_axi_awready;
  logic [7:0]   m_axi_arlen, m_axi_awlen;
  logic [2:0]   m_axi_arsize, m_axi_awsize, m_axi_arprot, m_axi_awprot;
  logic [1:0]   m_axi_arburst, m_axi_awburst;
  logic [3:0]   m_axi_arcache, m_axi_awcache;
  logic [511:0] m_axi_rdata, m_axi_wdata;
  logic [1:0]   m_axi_rresp, m_axi_bresp;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic         m_axi_bvalid, m_axi_bready;

  always #5 mem_clk = ~mem_clk;

  buddy_dram_port #(.ADDR_WID(32), .DRAM_DATA_WID(512), .TIMEOUT_CYC(16)) dut (
    .mem_clk(mem_clk), .mem_rst(mem_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct {
    logic [511:0] rdata;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [511:0] pat_a, pat_b, pat_c, pat_d;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per response handshake.
  always @(negedge mem_clk) begin
    exp_t e;
    if (!mem_rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got a response with rdata %0h err %0b, expected none", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [511:0] data, input logic [1:0] resp,
                         input int pre_beats, input int hold, input logic exp_err, input string tag);
    logic stable;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addr;
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check({tag, "_arvalid"}, m_axi_arvalid, 1'b1);
    check({tag, "_araddr"}, m_axi_araddr, addr & 32'hFFFF_FFC0);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    check({tag, "_rready"}, m_axi_rready, 1'b1);
    for (int i = 0; i < pre_beats; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b0;
      m_axi_rdata  = ~data;
      m_axi_rresp  = 2'b00;
      tick();
    end
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
    exp_q.push_back('{data, exp_err});
    if (hold > 0) rsp_ready = 1'b0;
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rdata  = '0;
    check({tag, "_rsp_latency"}, rsp_valid, 1'b1);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (!(rsp_valid === 1'b1 && rsp_rdata === data && rsp_err === exp_err &&
              cmd_ready === 1'b0 && m_axi_arvalid === 1'b0)) stable = 1'b0;
        tick();
      end
      check({tag, "_hold_stable"}, stable, 1'b1);
      rsp_ready = 1'b1;
    end
    tick();
    check({tag, "_idle_after"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    int aw_cyc, w_cyc, n;
    pat_a = {8{64'h0123_4567_89AB_CDEF}};
    pat_b = {16{32'h1111_2222}};
    pat_c = {16{32'hCAFE_F00D}};
    pat_d = {64{8'h5A}};
    mem_rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    repeat (3) tick();

    check("reset_ctrl", {cmd_ready, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                         m_axi_bready, rsp_valid, rsp_err}, 8'b1000_0000);
    check("reset_rdata", rsp_rdata, '0);
    mem_rst = 1'b0;
    tick();

    // 1: aligned-down address, constant burst fields
    do_read(32'h0000_1047, pat_a, 2'b00, 0, 0, 1'b0, "rd1");
    check("rd1_araddr_abs", m_axi_araddr, 32'h0000_1040);
    check("ar_consts", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot},
          {8'd0, 3'd6, 2'b01, 4'b0011, 3'd0});

    // 2: write with awready delayed 3 cycles
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_2000;
    cmd_wdata = pat_b; cmd_wstrb = 64'h0000_0000_FFFF_FFFF;
    m_axi_wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("wr_awaddr", m_axi_awaddr, 32'h0000_2000);
    check("wr_wdata", m_axi_wdata, pat_b);
    check("wr_wstrb", m_axi_wstrb, 64'h0000_0000_FFFF_FFFF);
    check("wr_wlast", m_axi_wlast, 1'b1);
    check("aw_consts", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot},
          {8'd0, 3'd6, 2'b01, 4'b0011, 3'd0});
    aw_cyc = 0;
    w_cyc  = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_axi_awready = 1'b1;
      if (m_axi_awvalid) aw_cyc++;
      if (m_axi_wvalid) w_cyc++;
      tick();
    end
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    check("wr_aw_cycles", aw_cyc, 4);
    check("wr_w_cycles", w_cyc, 1);
    check("wr_bready", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 3'b100);
    tick();
    check("wr_wait_b", rsp_valid, 1'b0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = 2'b00;
    exp_q.push_back('{512'd0, 1'b0});
    tick();
    m_axi_bvalid = 1'b0;
    check("wr_rsp_latency", rsp_valid, 1'b1);
    tick();

    // 3: SLVERR then a clean read
    do_read(32'h0000_3000, pat_c, 2'b10, 0, 0, 1'b1, "rd_slverr");
    do_read(32'h0000_3040, pat_d, 2'b00, 0, 0, 1'b0, "rd_clean");

    // 4: response back-pressure
    do_read(32'h0000_4080, pat_a, 2'b00, 0, 10, 1'b0, "rd_hold");

    // 5: missing rlast on the first beat
    do_read(32'h0000_50C1, pat_c, 2'b00, 1, 0, 1'b1, "rd_nolast");

    // reset while waiting for read data
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_6000;
    tick();
    cmd_valid = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    mem_rst = 1'b1;
    tick();
    mem_rst = 1'b0;
    check("midrst_ctrl", {cmd_ready, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                          m_axi_bready, rsp_valid, rsp_err}, 8'b1000_0000);
    check("midrst_regs", {m_axi_araddr, rsp_rdata}, '0);
    do_read(32'h0000_7000, pat_b, 2'b00, 0, 0, 1'b0, "rd_postrst");

`ifdef BUDDY_DRAM_TIMEOUT_EN
    // 6: watchdog with TIMEOUT_CYC=16
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_8000;
    tick();
    cmd_valid = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    exp_q.push_back('{512'd0, 1'b1});
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 16);
    tick();
    check("tmo_stale", {cmd_ready, m_axi_rready, m_axi_bready}, 3'b011);
    repeat (2) tick();
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = pat_d;
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    check("tmo_stale_clear", {cmd_ready, rsp_valid, m_axi_rready}, 3'b100);
    do_read(32'h0000_9000, pat_a, 2'b00, 0, 0, 1'b0, "rd_after_tmo");
`endif

    repeat (2) tick();
    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
